switch_allocator_rr: RTL and testbench

- Per-output round-robin allocator for the router crossbar. It arbitrates the route-calculator request matrix against downstream enables.
- Produces one-hot output grants to drive switch_onehot_packet and input grants that pop the input FIFOs.
- Adds per-input starvation aging so no input waits unboundedly behind a busy neighbour.
- Drop-in alternative to the existing switch allocation in router, with the same grant orientation (M words of N bits, transposed from requests).

---
 rtl/switch_allocator_rr.sv | 132 +++++++++++++
 tb/tb_switch_allocator_rr.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator_rr.sv
// Per-output round-robin switch allocator with per-input starvation aging.
// Optional per-output grant counters are enabled by defining SWALLOC_STATS_EN.
module switch_allocator_rr #(
   parameter int unsigned N            = 5,
   parameter int unsigned M            = 5,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ce,
   input  logic [0:M-1]            i_en,
   input  logic [0:N-1][0:M-1]     i_output_req,
   output logic [0:M-1][0:N-1]     o_output_grant,
   output logic [0:N-1]            o_input_grant
`ifdef SWALLOC_STATS_EN
   ,
   output logic [0:M-1][15:0]      o_stat_grants
`endif
);

   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

   logic [PTR_W-1:0]    ptr_q [M];
   logic [AGE_W-1:0]    age_q [N];
   logic [0:N-1][0:M-1] req_c;
   logic [0:N-1]        valid_c;
   logic [0:N-1]        starved_c;
   logic [0:N-1]        cand_c [M];
   logic [M-1:0]        hit_c;
   logic [PTR_W-1:0]    win_c [M];

   // Keep only the lowest-index request bit of each input.
   always_comb begin
      logic found;
      req_c     = '0;
      valid_c   = '0;
      starved_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         found = 1'b0;
         for (int unsigned m = 0; m < M; m++) begin
            if (!found && i_output_req[i][m]) begin
               req_c[i][m] = 1'b1;
               found       = 1'b1;
            end
         end
         valid_c[i]   = found;
         starved_c[i] = (age_q[i] >= AGE_MAX);
      end
   end

   // Per output: restrict to the starved class if non-empty, then search cyclically from ptr.
   always_comb begin
      logic [PTR_W-1:0] idx;
      o_output_grant = '0;
      idx            = '0;
      for (int unsigned m = 0; m < M; m++) begin
         cand_c[m] = '0;
         hit_c[m]  = 1'b0;
         win_c[m]  = '0;
         for (int unsigned i = 0; i < N; i++) begin
            cand_c[m][i] = req_c[i][m];
         end
         if ((cand_c[m] & starved_c) != '0) begin
            cand_c[m] = cand_c[m] & starved_c;
         end
         for (int unsigned k = 0; k < N; k++) begin
            idx = PTR_W'((32'(ptr_q[m]) + k) % N);
            if (!hit_c[m] && cand_c[m][idx]) begin
               hit_c[m] = 1'b1;
               win_c[m] = idx;
            end
         end
         if (hit_c[m] && ce && reset_n && i_en[m]) begin
            o_output_grant[m][win_c[m]] = 1'b1;
         end
      end
   end

   always_comb begin
      o_input_grant = '0;
      for (int unsigned m = 0; m < M; m++) begin
         o_input_grant = o_input_grant | o_output_grant[m];
      end
   end

   // Pointer advance past the winner; age saturates while a valid request is denied.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned m = 0; m < M; m++) ptr_q[m] <= '0;
         for (int unsigned i = 0; i < N; i++) age_q[i] <= '0;
      end else if (ce) begin
         for (int unsigned m = 0; m < M; m++) begin
            if (|o_output_grant[m]) begin
               ptr_q[m] <= (win_c[m] == PTR_LAST) ? '0 : win_c[m] + 1'b1;
            end
         end
         for (int unsigned i = 0; i < N; i++) begin
            if (o_input_grant[i] || !valid_c[i]) begin
               age_q[i] <= '0;
            end else if (age_q[i] != AGE_MAX) begin
               age_q[i] <= age_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef SWALLOC_STATS_EN
   logic [15:0] stat_q [M];

   // Saturating per-output grant counters; a grant already implies ce=1.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned m = 0; m < M; m++) stat_q[m] <= '0;
      end else begin
         for (int unsigned m = 0; m < M; m++) begin
            if ((|o_output_grant[m]) && (stat_q[m] != 16'hFFFF)) begin
               stat_q[m] <= stat_q[m] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      o_stat_grants = '0;
      for (int unsigned m = 0; m < M; m++) o_stat_grants[m] = stat_q[m];
   end
`endif

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed self-checking bench for switch_allocator_rr (N=5, M=5, STARVE_LIMIT=8).
module tb_switch_allocator_rr;

   localparam int unsigned N  = 5;
   localparam int unsigned M  = 5;
   localparam int unsigned SL = 8;

   logic                clk;
   logic                reset_n;
   logic                ce;
   logic [0:M-1]        en;
   logic [0:N-1][0:M-1] req;
   logic [0:M-1][0:N-1] ogrant;
   logic [0:N-1]        igrant;
`ifdef SWALLOC_STATS_EN
   logic [0:M-1][15:0]  stat;
`endif

   int checks   = 0;
   int failures = 0;

   switch_allocator_rr #(.N(N), .M(M), .STARVE_LIMIT(SL)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ce             (ce),
      .i_en           (en),
      .i_output_req   (req),
      .o_output_grant (ogrant),
      .o_input_grant  (igrant)
`ifdef SWALLOC_STATS_EN
      ,
      .o_stat_grants  (stat)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [0:M-1] oh_m(int unsigned m);
      logic [0:M-1] v;
      v    = '0;
      v[m] = 1'b1;
      return v;
   endfunction

   function automatic logic [0:N-1] oh_n(int unsigned i);
      logic [0:N-1] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [0:M-1][0:N-1] gm(int unsigned m, int unsigned i);
      logic [0:M-1][0:N-1] g;
      g       = '0;
      g[m][i] = 1'b1;
      return g;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ce      = 1'b1;
      reset_n = 1'b0;
      en      = '1;
      for (int i = 0; i < N; i++) req[i] = oh_m(2);

      // Grants suppressed while in reset
      tick();
      chk("reset_grant", 128'(ogrant), 128'(0));
      chk("reset_igrant", 128'(igrant), 128'(0));
      tick();
      chk("reset_grant2", 128'(ogrant), 128'(0));

      reset_n = 1'b1;
      #1;
      chk("post_reset_first", 128'(ogrant), 128'(gm(2, 0)));
      chk("post_reset_igrant", 128'(igrant), 128'(oh_n(0)));
      tick();
      chk("post_reset_ptr1", 128'(ogrant), 128'(gm(2, 1)));
      req = '0;
      tick();

      // Round-robin among inputs 1, 3, 4 on output 0
      req[1] = oh_m(0);
      req[3] = oh_m(0);
      req[4] = oh_m(0);
      begin
         int unsigned seq [6] = '{1, 3, 4, 1, 3, 4};
         for (int j = 0; j < 6; j++) begin
            #1;
            chk($sformatf("rr_grant%0d", j), 128'(ogrant), 128'(gm(0, seq[j])));
            chk($sformatf("rr_igrant%0d", j), 128'(igrant), 128'(oh_n(seq[j])));
            tick();
         end
      end
      req = '0;
      tick();

      // Input 2 starves behind a disabled output 1, then beats input 0 at ptr[1]=0
      req[2] = oh_m(1);
      en[1]  = 1'b0;
      for (int j = 0; j < 10; j++) begin
         #1;
         chk($sformatf("bp_nogrant%0d", j), 128'(ogrant), 128'(0));
         tick();
      end
      req[0] = oh_m(1);
      en     = '1;
      #1;
      chk("starved_wins", 128'(ogrant), 128'(gm(1, 2)));
      tick();
      chk("after_starved", 128'(ogrant), 128'(gm(1, 0)));
      req = '0;
      tick();

      // Malformed request: only lowest-index bit honoured
      req[3] = oh_m(1) | oh_m(4);
      #1;
      chk("malformed_grant", 128'(ogrant), 128'(gm(1, 3)));
      chk("malformed_row4", 128'(ogrant[4]), 128'(0));
      chk("malformed_igrant", 128'(igrant), 128'(oh_n(3)));
      req = '0;
      tick();

      // ce gating holds the pointer
      req[1] = oh_m(0);
      req[3] = oh_m(0);
      #1;
      chk("ce_pre", 128'(ogrant), 128'(gm(0, 1)));
      tick();
      ce = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk($sformatf("ce0_grant%0d", j), 128'(ogrant), 128'(0));
         chk($sformatf("ce0_igrant%0d", j), 128'(igrant), 128'(0));
         tick();
      end
      ce = 1'b1;
      #1;
      chk("ce_ptr_held", 128'(ogrant), 128'(gm(0, 3)));
      tick();
      req = '0;
      tick();

      // ce gating holds the age: input 3 at age 7 must not become starved
      req[3] = oh_m(0);
      en[0]  = 1'b0;
      repeat (7) tick();
      ce = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk($sformatf("ce0_age_grant%0d", j), 128'(ogrant), 128'(0));
         tick();
      end
      ce     = 1'b1;
      en     = '1;
      req[1] = oh_m(0);
      #1;
      chk("ce_age_held", 128'(ogrant), 128'(gm(0, 1)));
      req = '0;
      tick();

      // Reset asserted mid-operation kills grants immediately
      req[0] = oh_m(3);
      #1;
      chk("mid_pre", 128'(ogrant), 128'(gm(3, 0)));
      reset_n = 1'b0;
      #1;
      chk("mid_reset_grant", 128'(ogrant), 128'(0));
      chk("mid_reset_igrant", 128'(igrant), 128'(0));
      tick();

`ifdef SWALLOC_STATS_EN
      chk("stat_reset", 128'(stat), 128'(0));
      req     = '0;
      req[3]  = oh_m(3);
      reset_n = 1'b1;
      repeat (70000) tick();
      chk("stat_sat", 128'(stat[3]), 128'(16'hFFFF));
      chk("stat_other", 128'(stat[0]), 128'(0));
      repeat (3) tick();
      chk("stat_hold", 128'(stat[3]), 128'(16'hFFFF));
      reset_n = 1'b0;
      tick();
      chk("stat_clear", 128'(stat[3]), 128'(0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
